mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 29 ++
 rtl/div_radix2.sv | 69 ++++++
 rtl/mul_div_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the HI/LO multiply/divide unit.
// Holds the op encoding, FSM states, parameter defaults and the
// divide-by-zero quotient fill value.
package mdu_pkg;

   localparam int MDU_WIDTH_DEFAULT   = 32;
   localparam int MDU_MUL_LAT_DEFAULT = 2;

   // Every quotient bit reads as one on a divide by zero; HI returns the dividend.
   localparam logic DIV0_QUOT_BIT = 1'b1;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MADDU = 3'd5,
      OP_MSUB  = 3'd6,
      OP_MSUBU = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

endpackage

// File: rtl/div_radix2.sv
// div_radix2: iterative radix-2 restoring divider on unsigned operands.
// load starts a new division; done rises after WIDTH iterations and stays
// high until the next load. Sign handling belongs to the caller.
module div_radix2
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_div;
   logic [CW-1:0]    r_cnt;
   logic             r_active;
   logic             r_done;
   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;

   assign w_shifted = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shifted - {1'b0, r_div};

   // One quotient bit per edge: keep the trial difference unless it borrowed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_quo    <= '0;
         r_rem    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else if (load) begin
         r_quo    <= dividend;
         r_rem    <= '0;
         r_div    <= divisor;
         r_cnt    <= '0;
         r_active <= 1'b1;
         r_done   <= 1'b0;
      end else if (r_active) begin
         if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
         end else begin
            r_rem <= w_shifted[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
         end
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_ITER) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
         end
      end
   end

   assign done      = r_done;
   assign quotient  = r_quo;
   assign remainder = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide engine for the execute stage.
// Multiplies run through MUL_LAT product registers; divides use div_radix2
// on absolute values with the sign fix-up done on the way into HI/LO.
// Build option: define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 4-7).
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH   = MDU_WIDTH_DEFAULT,
   parameter int MUL_LAT = MDU_MUL_LAT_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   input  logic             flush,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(MUL_LAT + 2);

   mdu_op_e          w_op;
   mdu_state_e       r_state;
   mdu_state_e       w_nextState;
   logic             w_isMulOp;
   logic             w_isDivOp;
   logic             w_isSigned;
   logic             w_acceptMul;
   logic             w_acceptDiv;
   logic             w_commitMul;
   logic             w_commitDiv;
   logic [W2-1:0]    w_extA;
   logic [W2-1:0]    w_extB;
   logic [W2-1:0]    w_product;
   logic [W2-1:0]    w_mulResult;
   logic [W2-1:0]    r_pipe [MUL_LAT];
   logic [CW-1:0]    r_mulCnt;
   logic [CW-1:0]    w_mulLast;
   logic [WIDTH-1:0] w_absA;
   logic [WIDTH-1:0] w_absB;
   logic [WIDTH-1:0] w_quoRaw;
   logic [WIDTH-1:0] w_remRaw;
   logic [WIDTH-1:0] w_quoFix;
   logic [WIDTH-1:0] w_remFix;
   logic             w_divDone;
   logic             r_negQuo;
   logic             r_negRem;
   logic             r_divZero;
   logic [WIDTH-1:0] r_dividend;
   logic             r_valid;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   assign w_op       = mdu_op_e'(op);
   assign w_isDivOp  = (w_op == OP_DIV) || (w_op == OP_DIVU);
   assign w_isSigned = (w_op == OP_MULT) || (w_op == OP_DIV) ||
                       (w_op == OP_MADD) || (w_op == OP_MSUB);

   assign w_extA    = w_isSigned ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign w_extB    = w_isSigned ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign w_product = w_extA * w_extB;

`ifdef MDU_MADD_EN
   logic [W2-1:0] r_accIn;
   logic [W2-1:0] r_accRes;
   logic          r_isAcc;
   logic          r_isSub;

   assign w_isMulOp = (w_op == OP_MULT) || (w_op == OP_MULTU) || op[2];

   // Latch {HI,LO} at start; the accumulate stage trails the product pipe by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_accIn  <= '0;
         r_accRes <= '0;
         r_isAcc  <= 1'b0;
         r_isSub  <= 1'b0;
      end else begin
         if (w_acceptMul) begin
            r_accIn <= {hi_i, lo_i};
            r_isAcc <= op[2];
            r_isSub <= op[1];
         end
         r_accRes <= r_isSub ? (r_accIn - r_pipe[MUL_LAT-1]) : (r_accIn + r_pipe[MUL_LAT-1]);
      end
   end

   assign w_mulResult = r_isAcc ? r_accRes : r_pipe[MUL_LAT-1];
   assign w_mulLast   = r_isAcc ? CW'(MUL_LAT) : CW'(MUL_LAT - 1);
`else
   logic w_unusedAcc;

   assign w_isMulOp   = (w_op == OP_MULT) || (w_op == OP_MULTU);
   assign w_mulResult = r_pipe[MUL_LAT-1];
   assign w_mulLast   = CW'(MUL_LAT - 1);
   assign w_unusedAcc = ^{hi_i, lo_i};
`endif

   // State register; flush and reset both drop straight back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state plus accept/commit strobes; flush beats both start and completion.
   always_comb begin
      w_nextState = r_state;
      w_acceptMul = 1'b0;
      w_acceptDiv = 1'b0;
      w_commitMul = 1'b0;
      w_commitDiv = 1'b0;
      if (flush) begin
         w_nextState = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && w_isMulOp) begin
                  w_acceptMul = 1'b1;
                  w_nextState = ST_MUL;
               end else if (start && w_isDivOp) begin
                  w_acceptDiv = 1'b1;
                  w_nextState = ST_DIV;
               end
            end
            ST_MUL: begin
               if (r_mulCnt == w_mulLast) begin
                  w_commitMul = 1'b1;
                  w_nextState = ST_IDLE;
               end
            end
            ST_DIV: begin
               if (w_divDone) begin
                  w_commitDiv = 1'b1;
                  w_nextState = ST_IDLE;
               end
            end
            default: w_nextState = ST_IDLE;
         endcase
      end
   end

   // Product pipe: stage 0 captures the product at start, later stages just shift.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_LAT; i++) begin
            r_pipe[i] <= '0;
         end
      end else begin
         if (w_acceptMul) begin
            r_pipe[0] <= w_product;
         end
         for (int i = 1; i < MUL_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   // Counts edges spent in MUL so the commit lands exactly when the pipe is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mulCnt <= '0;
      end else if (w_acceptMul) begin
         r_mulCnt <= '0;
      end else if (r_state == ST_MUL) begin
         r_mulCnt <= r_mulCnt + 1'b1;
      end
   end

   assign w_absA = (w_isSigned && a[WIDTH-1]) ? -a : a;
   assign w_absB = (w_isSigned && b[WIDTH-1]) ? -b : b;

   // Remember the sign corrections and the raw dividend for the divide-by-zero case.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_negQuo   <= 1'b0;
         r_negRem   <= 1'b0;
         r_divZero  <= 1'b0;
         r_dividend <= '0;
      end else if (w_acceptDiv) begin
         r_negQuo   <= w_isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
         r_negRem   <= w_isSigned && a[WIDTH-1];
         r_divZero  <= (b == '0);
         r_dividend <= a;
      end
   end

   div_radix2 #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .load     (w_acceptDiv),
      .dividend (w_absA),
      .divisor  (w_absB),
      .done     (w_divDone),
      .quotient (w_quoRaw),
      .remainder(w_remRaw)
   );

   assign w_quoFix = r_divZero ? {WIDTH{DIV0_QUOT_BIT}} : (r_negQuo ? -w_quoRaw : w_quoRaw);
   assign w_remFix = r_divZero ? r_dividend : (r_negRem ? -w_remRaw : w_remRaw);

   // HI/LO result register with its one-cycle valid strobe; holds between commits.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_valid <= w_commitMul || w_commitDiv;
         if (w_commitMul) begin
            r_hi <= w_mulResult[W2-1:WIDTH];
            r_lo <= w_mulResult[WIDTH-1:0];
         end else if (w_commitDiv) begin
            r_hi <= w_remFix;
            r_lo <= w_quoFix;
         end
      end
   end

   assign busy  = (r_state != ST_IDLE);
   assign valid = r_valid;
   assign hi_o  = r_hi;
   assign lo_o  = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit with a behavioural
// arithmetic reference model, directed boundary cases and random operations.
module tb_mul_div_unit;

   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hiIn;
   logic [31:0] loIn;
   logic        busy;
   logic        valid;
   logic [31:0] hiOut;
   logic [31:0] loOut;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] holdHi;
   logic [31:0] holdLo;

   mul_div_unit #(
      .WIDTH  (WIDTH),
      .MUL_LAT(MUL_LAT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .hi_i (hiIn),
      .lo_i (loIn),
      .flush(flush),
      .busy (busy),
      .valid(valid),
      .hi_o (hiOut),
      .lo_o (loOut)
   );

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // Hard time limit so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Arithmetic reference: plain 64-bit multiply/divide on sign- or zero-extended operands.
   function automatic void refModel(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                    input logic [31:0] hh, input logic [31:0] ll,
                                    output logic [31:0] eh, output logic [31:0] el,
                                    output int lat, output bit legal);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] q;
      logic signed [63:0] r;
      logic [63:0]        res;
      bit                 sgn;
      sgn   = (o[0] == 1'b0);
      sa    = sgn ? {{32{aa[31]}}, aa} : {32'b0, aa};
      sb    = sgn ? {{32{bb[31]}}, bb} : {32'b0, bb};
      legal = 1'b1;
      lat   = MUL_LAT;
      res   = '0;
      case (o)
         3'd0, 3'd1: res = sa * sb;
         3'd2, 3'd3: begin
            lat = WIDTH + 1;
            if (bb == 32'd0) begin
               res = {aa, 32'hFFFF_FFFF};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
`ifdef MDU_MADD_EN
            lat = MUL_LAT + 1;
            res = o[1] ? ({hh, ll} - 64'(sa * sb)) : ({hh, ll} + 64'(sa * sb));
`else
            res   = {hh, ll};
            legal = 1'b0;
`endif
         end
      endcase
      eh = res[63:32];
      el = res[31:0];
   endfunction

   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                input logic [31:0] hh, input logic [31:0] ll);
      op    = o;
      a     = aa;
      b     = bb;
      hiIn  = hh;
      loIn  = ll;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic runEdges(input int n, output int validCnt, output int busyCnt);
      validCnt = 0;
      busyCnt  = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (valid) validCnt++;
         if (busy) busyCnt++;
      end
   endtask

   task automatic awaitValid(output int lat, output int busyCnt);
      lat     = -1;
      busyCnt = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            lat = k;
            break;
         end
         if (busy) busyCnt++;
      end
   endtask

   // Issue one operation and check latency, busy profile and HI/LO against the model.
   task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] hh, input logic [31:0] ll);
      logic [31:0] eh;
      logic [31:0] el;
      int          expLat;
      int          lat;
      int          busyCnt;
      int          validCnt;
      bit          legal;
      refModel(o, aa, bb, hh, ll, eh, el, expLat, legal);
      applyStimulus(o, aa, bb, hh, ll);
      if (legal) begin
         checkOutput({tag, "_busyStart"}, 64'(busy), 64'd1);
         awaitValid(lat, busyCnt);
         checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
         checkOutput({tag, "_hi"}, 64'(hiOut), 64'(eh));
         checkOutput({tag, "_lo"}, 64'(loOut), 64'(el));
         checkOutput({tag, "_busyAtValid"}, 64'(busy), 64'd0);
         checkOutput({tag, "_busyCycles"}, 64'(busyCnt), 64'(expLat - 1));
         holdHi = eh;
         holdLo = el;
      end else begin
         checkOutput({tag, "_illegalBusy0"}, 64'(busy), 64'd0);
         runEdges(MUL_LAT + 4, validCnt, busyCnt);
         checkOutput({tag, "_illegalValid"}, 64'(validCnt), 64'd0);
         checkOutput({tag, "_illegalBusy"}, 64'(busyCnt), 64'd0);
         checkOutput({tag, "_illegalHold"}, {hiOut, loOut}, {holdHi, holdLo});
      end
   endtask

   function automatic logic [31:0] randOperand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int validCnt;
      int busyCnt;
      rst    = 1'b1;
      start  = 1'b0;
      flush  = 1'b0;
      op     = 3'd0;
      a      = '0;
      b      = '0;
      hiIn   = '0;
      loIn   = '0;
      holdHi = '0;
      holdLo = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_valid", 64'(valid), 64'd0);
      checkOutput("reset_hilo", {hiOut, loOut}, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Directed arithmetic, with the known answers pinned as constants too
      runOp("mult", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
      checkOutput("mult_const", {hiOut, loOut}, 64'hFFFF_FFFF_FFFF_FFFE);
      runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
      checkOutput("multu_const", {hiOut, loOut}, 64'h0000_0001_FFFF_FFFE);
      runOp("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
      checkOutput("div_const", {hiOut, loOut}, 64'hFFFF_FFFF_FFFF_FFFD);
      runOp("divu", 3'd3, 32'd7, 32'd2, 0, 0);
      checkOutput("divu_const", {hiOut, loOut}, 64'h0000_0001_0000_0003);
      runOp("div0", 3'd2, 32'h1234_5678, 32'h0, 0, 0);
      checkOutput("div0_const", {hiOut, loOut}, 64'h1234_5678_FFFF_FFFF);
      runOp("divOvf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      checkOutput("divOvf_const", {hiOut, loOut}, 64'h0000_0000_8000_0000);

      // Back-to-back: MULTU issued in the DIV valid cycle
      runOp("b2bDiv", 3'd3, 32'd1000, 32'd9, 0, 0);
      runOp("b2bMul", 3'd1, 32'h0001_0000, 32'h0001_0000, 0, 0);

      // Flush in the valid cycle leaves the committed result alone
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flushAtValid_hilo", {hiOut, loOut}, {holdHi, holdLo});
      checkOutput("flushAtValid_valid", 64'(valid), 64'd0);

      // Divide in flight: stray start at edge 5, flush at edge 10
      applyStimulus(3'd3, 32'd1000, 32'd7, 0, 0);
      runEdges(4, validCnt, busyCnt);
      checkOutput("inflight_busyEarly", 64'(busyCnt), 64'd4);
      op    = 3'd1;
      a     = 32'd5;
      b     = 32'd6;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("inflight_ignoredStart", 64'(busy), 64'd1);
      runEdges(4, validCnt, busyCnt);
      checkOutput("inflight_noEarlyValid", 64'(validCnt), 64'd0);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_busy", 64'(busy), 64'd0);
      checkOutput("flush_valid", 64'(valid), 64'd0);
      checkOutput("flush_hilo", {hiOut, loOut}, {holdHi, holdLo});
      runEdges(40, validCnt, busyCnt);
      checkOutput("flush_noLateValid", 64'(validCnt), 64'd0);
      checkOutput("flush_noLateBusy", 64'(busyCnt), 64'd0);

      // Flush together with start: start is discarded
      op    = 3'd1;
      start = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      checkOutput("flushStart_busy", 64'(busy), 64'd0);
      runEdges(MUL_LAT + 3, validCnt, busyCnt);
      checkOutput("flushStart_valid", 64'(validCnt), 64'd0);

      // Reset at edge 12 of a new divide
      applyStimulus(3'd2, 32'hFFFF_0000, 32'd3, 0, 0);
      runEdges(11, validCnt, busyCnt);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midReset_busy", 64'(busy), 64'd0);
      checkOutput("midReset_valid", 64'(valid), 64'd0);
      checkOutput("midReset_hilo", {hiOut, loOut}, 64'd0);
      holdHi = '0;
      holdLo = '0;
      runEdges(40, validCnt, busyCnt);
      checkOutput("midReset_noValid", 64'(validCnt), 64'd0);

      // Accumulate op: legal only when the option is built in
      runOp("madd", 3'd4, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0, 32'h0000_0005);
`ifdef MDU_MADD_EN
      checkOutput("madd_const", {hiOut, loOut}, 64'h0000_0000_0000_0002);
`endif

      // Randomized operations against the reference model
      for (int n = 0; n < 40; n++) begin
         runOp($sformatf("rand%0d", n), 3'($urandom_range(0, 7)), randOperand(), randOperand(),
               $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
